// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues fetch addresses to an sram-like memory and returns
// {pc, inst} to decode in order. Define IF_ADEL_CHECK_EN to trap misaligned fetch_pc as adel.
module inst_fetch_buf #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   output logic        fetch_ready,
   input  logic        flush,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
`ifdef IF_ADEL_CHECK_EN
   output logic        out_adel,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = $clog2(DEPTH + 1);
   localparam int CW = PW + 2;
   localparam logic [PW:0]   P_ONE = 1;
   localparam logic [DW-1:0] D_ONE = 1;

   logic [PW:0]   wptr_q, wptr_d, fptr_q, fptr_d, rptr_q, rptr_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [31:0]   pc_q   [DEPTH];
   logic [31:0]   inst_q [DEPTH];

   logic [PW:0]   occ, inflight;
   logic [CW-1:0] used;
   logic          room, req_acc, adel_acc, fill, drop, pop;

   // Slots still owed a discarded data_ok beat count against capacity.
   assign occ      = wptr_q - rptr_q;
   assign inflight = wptr_q - fptr_q;
   assign used     = CW'(occ) + CW'(dcnt_q);
   assign room     = used < CW'(DEPTH);

`ifdef IF_ADEL_CHECK_EN
   logic misal;
   logic adel_q [DEPTH];
   assign misal    = fetch_pc[1:0] != 2'b00;
   assign inst_req = fetch_valid & room & ~flush & ~misal;
   // Only taken once all earlier requests have filled, so order is kept.
   assign adel_acc = fetch_valid & room & ~flush & misal & (wptr_q == fptr_q);
   assign out_adel = adel_q[rptr_q[PW-1:0]];
`else
   assign inst_req = fetch_valid & room & ~flush;
   assign adel_acc = 1'b0;
`endif

   assign inst_addr   = fetch_pc;
   assign req_acc     = inst_req & inst_addr_ok;
   assign fetch_ready = req_acc | adel_acc;

   assign drop = inst_data_ok & (dcnt_q != '0);
   assign fill = inst_data_ok & (dcnt_q == '0) & ~flush;

   assign out_valid = rptr_q != fptr_q;
   assign out_pc    = pc_q[rptr_q[PW-1:0]];
   assign out_inst  = inst_q[rptr_q[PW-1:0]];
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      wptr_d = wptr_q;
      fptr_d = fptr_q;
      rptr_d = rptr_q;
      dcnt_d = dcnt_q;
      if (flush) begin
         // Any beat returning this cycle is pre-flush and already in inflight or dcnt.
         wptr_d = rptr_q;
         fptr_d = rptr_q;
         dcnt_d = DW'(CW'(dcnt_q) + CW'(inflight) - CW'(inst_data_ok));
      end else begin
         if (fetch_ready)       wptr_d = wptr_q + P_ONE;
         if (fill | adel_acc)   fptr_d = fptr_q + P_ONE;
         if (pop)               rptr_d = rptr_q + P_ONE;
         if (drop)              dcnt_d = dcnt_q - D_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q <= '0;
         fptr_q <= '0;
         rptr_q <= '0;
         dcnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
`ifdef IF_ADEL_CHECK_EN
            adel_q[i] <= 1'b0;
`endif
         end
      end else begin
         wptr_q <= wptr_d;
         fptr_q <= fptr_d;
         rptr_q <= rptr_d;
         dcnt_q <= dcnt_d;
         if (fetch_ready) begin
            pc_q[wptr_q[PW-1:0]] <= fetch_pc;
`ifdef IF_ADEL_CHECK_EN
            adel_q[wptr_q[PW-1:0]] <= adel_acc;
`endif
         end
         if (adel_acc)
            inst_q[wptr_q[PW-1:0]] <= '0;
         else if (fill)
            inst_q[fptr_q[PW-1:0]] <= inst_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: table vectors for streaming and backpressure,
// hand sequences for full, flush and reset corner cases.
module tb_inst_fetch_buf;
   logic        clk = 1'b0;
   logic        resetn;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
`ifdef IF_ADEL_CHECK_EN
   logic        out_adel;
`endif

   always #5 clk = ~clk;

   inst_fetch_buf #(.DEPTH(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .fetch_valid  (fetch_valid),
      .fetch_pc     (fetch_pc),
      .fetch_ready  (fetch_ready),
      .flush        (flush),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
`ifdef IF_ADEL_CHECK_EN
      .out_adel     (out_adel),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_inst     (out_inst)
   );

   typedef struct {
      logic        fv;
      logic [31:0] pc;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        ordy;
      logic        fl;
      logic        e_req;
      logic        e_fr;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int failures = 0;

   function automatic vec_t mk(logic fv, logic [31:0] pc, logic aok, logic dok,
                               logic [31:0] rdata, logic ordy, logic fl, logic e_req,
                               logic e_fr, logic e_ov, logic [31:0] e_pc, logic [31:0] e_inst);
      vec_t v;
      v.fv = fv; v.pc = pc; v.aok = aok; v.dok = dok; v.rdata = rdata; v.ordy = ordy;
      v.fl = fl; v.e_req = e_req; v.e_fr = e_fr; v.e_ov = e_ov; v.e_pc = e_pc;
      v.e_inst = e_inst;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs mid-cycle; outputs are checked 1ns later, well before posedge.
   task automatic drv(input logic fv, input logic [31:0] pc, input logic aok, input logic dok,
                      input logic [31:0] rdata, input logic ordy, input logic fl);
      @(negedge clk);
      fetch_valid = fv; fetch_pc = pc; inst_addr_ok = aok; inst_data_ok = dok;
      inst_rdata = rdata; out_ready = ordy; flush = fl;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      fetch_valid = 0; fetch_pc = 0; inst_addr_ok = 0; inst_data_ok = 0;
      inst_rdata = 0; out_ready = 0; flush = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
   endtask

   task automatic apply(input vec_t v, input string tag);
      drv(v.fv, v.pc, v.aok, v.dok, v.rdata, v.ordy, v.fl);
      chk({tag, "_req"}, 32'(inst_req), 32'(v.e_req));
      chk({tag, "_fready"}, 32'(fetch_ready), 32'(v.e_fr));
      chk({tag, "_ovalid"}, 32'(out_valid), 32'(v.e_ov));
      if (v.e_req) chk({tag, "_addr"}, inst_addr, v.pc);
      if (v.e_ov) begin
         chk({tag, "_pc"}, out_pc, v.e_pc);
         chk({tag, "_inst"}, out_inst, v.e_inst);
      end
   endtask

   initial begin
      int acc;
      logic [31:0] pcf;

      // Streaming: 3 fetches, data one cycle after accept, decode always ready.
      tbl.push_back(mk(1, 32'hbfc00000, 1, 0, 32'h0,        1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'hbfc00004, 1, 1, 32'h24010001, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'hbfc00008, 1, 1, 32'h24020002, 1, 0, 1, 1, 1, 32'hbfc00000, 32'h24010001));
      tbl.push_back(mk(0, 32'h0,        1, 1, 32'h24030003, 1, 0, 0, 0, 1, 32'hbfc00004, 32'h24020002));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 0, 0, 0, 1, 32'hbfc00008, 32'h24030003));
      tbl.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0));
      // Backpressure: out_ready toggles 1010 while 4 entries fill and drain.
      tbl.push_back(mk(1, 32'hbfc00100, 1, 0, 32'h0,        1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'hbfc00104, 1, 1, 32'h11110000, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'hbfc00108, 1, 1, 32'h11110001, 1, 0, 1, 1, 1, 32'hbfc00100, 32'h11110000));
      tbl.push_back(mk(1, 32'hbfc0010c, 1, 1, 32'h11110002, 0, 0, 1, 1, 1, 32'hbfc00104, 32'h11110001));
      tbl.push_back(mk(0, 32'h0,        1, 1, 32'h11110003, 1, 0, 0, 0, 1, 32'hbfc00104, 32'h11110001));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 1, 32'hbfc00108, 32'h11110002));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 0, 0, 0, 1, 32'hbfc00108, 32'h11110002));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 1, 32'hbfc0010c, 32'h11110003));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 0, 0, 0, 1, 32'hbfc0010c, 32'h11110003));
      tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0));

      do_reset();
      chk("reset_ovalid", 32'(out_valid), 32'd0);
      chk("reset_pc", out_pc, 32'd0);
      chk("reset_inst", out_inst, 32'd0);
      chk("reset_req", 32'(inst_req), 32'd0);
`ifdef IF_ADEL_CHECK_EN
      chk("reset_adel", 32'(out_adel), 32'd0);
`endif

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Full: no pops, memory always ready; exactly DEPTH accepts.
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         pcf = 32'h00000200 + 32'(acc * 4);
         drv(1, pcf, 1, 0, 0, 0, 0);
         if (fetch_ready) acc++;
      end
      chk("full_accepts", 32'(acc), 32'd4);
      chk("full_req_low", 32'(inst_req), 32'd0);
      for (int k = 0; k < 4; k++) begin
         drv(1, pcf, 1, 1, 32'ha0000000 + 32'(k), 0, 0);
         chk("full_fill_req_low", 32'(inst_req), 32'd0);
      end
      drv(1, pcf, 1, 0, 0, 1, 0);
      chk("full_pop_valid", 32'(out_valid), 32'd1);
      chk("full_pop_pc", out_pc, 32'h00000200);
      chk("full_pop_inst", out_inst, 32'ha0000000);
      acc = 0;
      for (int k = 0; k < 3; k++) begin
         drv(1, pcf, 1, 0, 0, 0, 0);
         if (fetch_ready) acc++;
      end
      chk("full_one_more", 32'(acc), 32'd1);
      chk("full_next_head", out_pc, 32'h00000204);

      // Reset with a full queue clears everything.
      do_reset();
      chk("midreset_ovalid", 32'(out_valid), 32'd0);
      chk("midreset_pc", out_pc, 32'd0);
      chk("midreset_inst", out_inst, 32'd0);

      // Flush with two in flight; only the post-flush fetch reaches decode.
      drv(1, 32'hbfc00300, 1, 0, 0, 0, 0);
      chk("fl2_acc0", 32'(fetch_ready), 32'd1);
      drv(1, 32'hbfc00304, 1, 0, 0, 0, 0);
      chk("fl2_acc1", 32'(fetch_ready), 32'd1);
      drv(1, 32'hbfc00308, 1, 0, 0, 1, 1);
      chk("fl2_flush_req", 32'(inst_req), 32'd0);
      chk("fl2_flush_fready", 32'(fetch_ready), 32'd0);
      drv(1, 32'hbfc00380, 1, 0, 0, 0, 0);
      chk("fl2_new_acc", 32'(fetch_ready), 32'd1);
      chk("fl2_new_ovalid", 32'(out_valid), 32'd0);
      drv(0, 0, 0, 1, 32'hdead0000, 0, 0);
      chk("fl2_old0_ovalid", 32'(out_valid), 32'd0);
      drv(0, 0, 0, 1, 32'hdead0001, 0, 0);
      chk("fl2_old1_ovalid", 32'(out_valid), 32'd0);
      drv(0, 0, 0, 1, 32'h38000000, 0, 0);
      chk("fl2_newdata_ovalid", 32'(out_valid), 32'd0);
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("fl2_out_valid", 32'(out_valid), 32'd1);
      chk("fl2_out_pc", out_pc, 32'hbfc00380);
      chk("fl2_out_inst", out_inst, 32'h38000000);
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("fl2_drained", 32'(out_valid), 32'd0);

      // Flush coinciding with data_ok, 3 outstanding: 2 beats left to discard.
      do_reset();
      drv(1, 32'hbfc00400, 1, 0, 0, 0, 0);
      drv(1, 32'hbfc00404, 1, 0, 0, 0, 0);
      drv(1, 32'hbfc00408, 1, 0, 0, 0, 0);
      drv(0, 0, 0, 1, 32'hdead1000, 1, 1);
      drv(1, 32'hbfc00500, 1, 0, 0, 0, 0);
      chk("fl3_empty_after", 32'(out_valid), 32'd0);
      chk("fl3_acc0", 32'(fetch_ready), 32'd1);
      drv(1, 32'hbfc00504, 1, 0, 0, 0, 0);
      chk("fl3_acc1", 32'(fetch_ready), 32'd1);
      drv(1, 32'hbfc00508, 1, 0, 0, 0, 0);
      chk("fl3_room_limit", 32'(inst_req), 32'd0);
      drv(0, 0, 0, 1, 32'hdead1001, 0, 0);
      drv(0, 0, 0, 1, 32'hdead1002, 0, 0);
      chk("fl3_drop_ovalid", 32'(out_valid), 32'd0);
      drv(0, 0, 0, 1, 32'h55550000, 0, 0);
      chk("fl3_fill_ovalid", 32'(out_valid), 32'd0);
      drv(0, 0, 0, 1, 32'h55550001, 1, 0);
      chk("fl3_out0_pc", out_pc, 32'hbfc00500);
      chk("fl3_out0_inst", out_inst, 32'h55550000);
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("fl3_out1_pc", out_pc, 32'hbfc00504);
      chk("fl3_out1_inst", out_inst, 32'h55550001);
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("fl3_drained", 32'(out_valid), 32'd0);

`ifdef IF_ADEL_CHECK_EN
      // Misaligned pc: no memory request, entry carries adel with inst 0.
      do_reset();
      drv(1, 32'hbfc00002, 0, 0, 0, 0, 0);
      chk("adel_req", 32'(inst_req), 32'd0);
      chk("adel_fready", 32'(fetch_ready), 32'd1);
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("adel_ovalid", 32'(out_valid), 32'd1);
      chk("adel_flag", 32'(out_adel), 32'd1);
      chk("adel_pc", out_pc, 32'hbfc00002);
      chk("adel_inst", out_inst, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
